seg7_scan_controller: RTL and testbench
=======================================

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 SHALL have parameter w_digit, default 4: number of multiplexed digits, minimum 2.
REQ-002 SHALL have parameter digit_hold_cycles, default 50000: clk cycles each digit stays selected, minimum 2.
REQ-003 SHALL have parameter dead_cycles, default 1: blanked cycles at the start of each digit slot, less than digit_hold_cycles.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port in_valid, input, 1: new display frame offered.
REQ-007 SHALL have port in_ready, output, 1: pending buffer empty, frame can be accepted.
REQ-008 SHALL have port in_value, input, 4*w_digit: hex nibbles; nibble i is bits [4i+3:4i], digit 0 rightmost.
REQ-009 SHALL have port in_dot, input, w_digit: decimal point per digit.
REQ-010 SHALL have port in_enable, input, w_digit: digit shown when 1.
REQ-011 SHALL have port abcdefgh, output, 8: segments, bit 7 = a … bit 0 = h (dot), active-high.
REQ-012 SHALL have port digit, output, w_digit: one-hot or zero, active-high digit select.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when the last digit slot ends.

Function
REQ-014 SHALL run a prescaler counting 0..digit_hold_cycles-1 and wrapping to 0.
REQ-015 SHALL advance the digit index 0→1→…→w_digit-1→0 when the prescaler wraps.
REQ-016 SHALL pulse frame_done in the cycle the index wraps from w_digit-1 to 0; this is the frame boundary.
REQ-017 SHALL accept a frame on in_valid && in_ready into a pending buffer (value, dot, enable) and clear in_ready the next cycle.
REQ-018 SHALL copy a full pending buffer to the active buffer at the frame boundary and set in_ready the next cycle; the active buffer SHALL never change mid-frame.
REQ-019 SHALL NOT bypass: a frame accepted in the frame-boundary cycle waits for the following boundary.
REQ-020 SHALL drive digit and abcdefgh with all zeros while the prescaler < dead_cycles, and for a disabled digit.
REQ-021 SHALL otherwise set digit[index]=1 and abcdefgh = segment pattern of the active nibble, with h = the active dot bit.
REQ-022 SHALL register digit, abcdefgh and frame_done; their latency from the prescaler/index state is 1 cycle.
REQ-023 SHALL ignore in_valid while in_ready=0; upstream holds the data.

Reset
REQ-024 SHALL on rst clear prescaler, index, active and pending buffers, digit, abcdefgh and frame_done to 0, and set in_ready to 1.
REQ-025 SHALL, on reset mid-frame, discard pending data; the display stays blank until the first loaded frame reaches a boundary.

Configuration
REQ-026 SHALL, with SEG7_LEADING_ZERO_BLANK_EN defined, blank digit i (i>0) when its nibble and all higher-index enabled nibbles are 0; digit 0 is never suppressed.
REQ-027 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, show every enabled digit, including leading zeros.

Structure
REQ-028 SHALL place in package seg7_pkg the 16-entry hex-to-abcdefg pattern constant and the segment bit-position constants.
REQ-029 SHALL use sub-module seg7_hex_decoder (combinational, nibble → 7 segments) fed from the active buffer.

Verification (w_digit=4, digit_hold_cycles=4, dead_cycles=1)
REQ-030 Reset released, no load → digit=0 and abcdefgh=0 for 3 frames; frame_done pulses every 16 cycles.
REQ-031 Load value=16'h1234, enable=4'hF, dot=0 → from next boundary, slot 0: digit=0001, abcdefgh=8'b0110_0110 ('4') for 3 cycles after 1 dead cycle; slot 3 shows '1'.
REQ-032 Load at the frame-boundary cycle → in_ready low until the boundary after next; old frame is shown for one more full frame.
REQ-033 Second in_valid while pending is full → ignored; after the boundary, in_ready=1 and the next offer is accepted.
REQ-034 value=16'h0050, enable=F, with macro → digits 3 and 2 blank, digits 1 and 0 show '5','0'; without macro → all four show.
REQ-035 Assert rst mid-slot with a pending frame → all outputs 0 within the same cycle (async), in_ready=1 after release, and the pending frame is lost.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: hex glyph table and
// segment bit positions within the abcdefgh output byte.
package seg7_pkg;

  localparam int seg_a = 7;
  localparam int seg_b = 6;
  localparam int seg_c = 5;
  localparam int seg_d = 4;
  localparam int seg_e = 3;
  localparam int seg_f = 2;
  localparam int seg_g = 1;
  localparam int seg_h = 0;

  // Glyphs as abcdefg with a in bit 6; listed from F down to 0.
  localparam logic [15:0][6:0] hex_seg = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [7:0] pack_segs(input logic [6:0] s, input logic dot);
    logic [7:0] r;
    r        = '0;
    r[seg_a] = s[6];
    r[seg_b] = s[5];
    r[seg_c] = s[4];
    r[seg_d] = s[3];
    r[seg_e] = s[2];
    r[seg_f] = s[1];
    r[seg_g] = s[0];
    r[seg_h] = dot;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to abcdefg glyph lookup (a in bit 6), zero latency.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = hex_seg[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scanner with double-buffered frames, outputs registered (1 cycle).
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit 0.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int w_digit           = 4,
  parameter int digit_hold_cycles = 50000,
  parameter int dead_cycles       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*w_digit-1:0] in_value,
  input  logic [w_digit-1:0]   in_dot,
  input  logic [w_digit-1:0]   in_enable,
  output logic [7:0]           abcdefgh,
  output logic [w_digit-1:0]   digit,
  output logic                 frame_done
);

  localparam int cnt_w = $clog2(digit_hold_cycles);
  localparam int idx_w = $clog2(w_digit);
  localparam logic [cnt_w-1:0] hold_max = cnt_w'(digit_hold_cycles - 1);
  localparam logic [cnt_w-1:0] dead_c   = cnt_w'(dead_cycles);
  localparam logic [idx_w-1:0] idx_max  = idx_w'(w_digit - 1);

  logic [cnt_w-1:0]     cnt;
  logic [idx_w-1:0]     idx;
  logic [4*w_digit-1:0] act_val, pend_val;
  logic [w_digit-1:0]   act_dot, pend_dot;
  logic [w_digit-1:0]   act_en, pend_en;
  logic                 pend_full;

  logic                 wrap, boundary, show;
  logic [3:0]           nib;
  logic [6:0]           glyph;
  logic [w_digit-1:0]   sel;
  logic [w_digit-1:0]   lz;

  assign in_ready = ~pend_full;
  assign wrap     = (cnt == hold_max);
  assign boundary = wrap && (idx == idx_max);
  assign nib      = act_val[idx*4 +: 4];

  seg7_hex_decoder u_dec (
    .nibble (nib),
    .segs   (glyph)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_above;
  // Walk from the top digit down; disabled digits do not stop the zero run.
  always_comb begin
    zero_above = 1'b1;
    lz         = '0;
    for (int i = w_digit - 1; i > 0; i--) begin
      if (zero_above && act_val[4*i +: 4] == 4'd0) lz[i] = 1'b1;
      if (act_en[i] && act_val[4*i +: 4] != 4'd0) zero_above = 1'b0;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

  assign show = (cnt >= dead_c) && act_en[idx] && !lz[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dot    <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dot   <= '0;
      pend_en    <= '0;
      pend_full  <= 1'b0;
      digit      <= '0;
      abcdefgh   <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx == idx_max) ? '0 : idx + 1'b1;
      frame_done <= boundary;

      if (show) begin
        digit    <= sel;
        abcdefgh <= pack_segs(glyph, act_dot[idx]);
      end else begin
        digit    <= '0;
        abcdefgh <= '0;
      end

      // A frame accepted in the boundary cycle lands in pending and waits a full frame.
      if (boundary && pend_full) begin
        act_val   <= pend_val;
        act_dot   <= pend_dot;
        act_en    <= pend_en;
        pend_full <= 1'b0;
      end else if (in_valid && !pend_full) begin
        pend_val  <= in_value;
        pend_dot  <= in_dot;
        pend_en   <= in_enable;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller (w_digit=4, hold=4, dead=1).
module tb_seg7_scan_controller;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_value;
  logic [3:0]    in_dot;
  logic [3:0]    in_enable;
  logic [7:0]    abcdefgh;
  logic [3:0]    digit;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int n;

  // Hand-written glyphs as abcdefgh with h=0.
  logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  seg7_scan_controller #(
    .w_digit           (W),
    .digit_hold_cycles (H),
    .dead_cycles       (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_dot     (in_dot),
    .in_enable  (in_enable),
    .abcdefgh   (abcdefgh),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_show(input logic [15:0] v, input logic [3:0] en, input int s);
    logic za;
    if (!en[s]) return 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      za = 1'b1;
      for (int j = s + 1; j < W; j++)
        if (en[j] && v[4*j +: 4] != 4'd0) za = 1'b0;
      if (za && v[4*s +: 4] == 4'd0) return 1'b0;
    end
`else
    za = 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic wait_frame(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 40);
    if (!frame_done) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // Entered in a frame_done cycle; checks the 16 following cycles.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] dt,
                             input logic [3:0] en, input string tag);
    int s, p;
    logic vis;
    logic [7:0] g, es;
    logic [3:0] ed;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      s   = (k - 1) / 4;
      p   = (k - 1) % 4;
      vis = (p >= D) && exp_show(v, en, s);
      g   = seg_tbl[v[4*s +: 4]];
      ed  = vis ? (4'b0001 << s) : 4'b0000;
      es  = vis ? {g[7:1], dt[s]} : 8'h00;
      check($sformatf("%s s%0d p%0d digit", tag, s, p), {28'd0, digit}, {28'd0, ed});
      check($sformatf("%s s%0d p%0d seg", tag, s, p), {24'd0, abcdefgh}, {24'd0, es});
      check($sformatf("%s k%0d fd", tag, k), {31'd0, frame_done}, {31'd0, (k == 16)});
    end
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] dt, input logic [3:0] en);
    in_value  = v;
    in_dot    = dt;
    in_enable = en;
    in_valid  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_dot = '0; in_enable = '0;
    #12;
    check("rst digit", {28'd0, digit}, 32'd0);
    check("rst seg", {24'd0, abcdefgh}, 32'd0);
    check("rst fd", {31'd0, frame_done}, 32'd0);
    check("rst ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    wait_frame("first", n);
    check("first fd period", n, 32'd16);
    repeat (3) check_frame(16'h0000, 4'h0, 4'h0, "blank");

    repeat (2) @(negedge clk);
    check("ready idle", {31'd0, in_ready}, 32'd1);
    offer(16'h1234, 4'h0, 4'hF);
    @(negedge clk);
    in_valid = 1'b0;
    check("ready clr", {31'd0, in_ready}, 32'd0);
    wait_frame("load1", n);
    check("ready set", {31'd0, in_ready}, 32'd1);
    check_frame(16'h1234, 4'h0, 4'hF, "f1234");

    // Offer in the boundary cycle itself (last cycle before frame_done).
    repeat (15) @(negedge clk);
    check("bnd ready", {31'd0, in_ready}, 32'd1);
    offer(16'hABCD, 4'b0101, 4'hF);
    @(negedge clk);
    in_valid = 1'b0;
    check("bnd fd", {31'd0, frame_done}, 32'd1);
    check("bnd ready low", {31'd0, in_ready}, 32'd0);
    check_frame(16'h1234, 4'h0, 4'hF, "old");
    check("bnd ready back", {31'd0, in_ready}, 32'd1);
    check_frame(16'hABCD, 4'b0101, 4'hF, "fabcd");

    // Second offer while pending is full must be ignored.
    repeat (2) @(negedge clk);
    offer(16'h0050, 4'h0, 4'hF);
    @(negedge clk);
    check("full ready", {31'd0, in_ready}, 32'd0);
    offer(16'h9999, 4'hF, 4'h0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_frame("load50", n);
    check("ready50", {31'd0, in_ready}, 32'd1);
    check_frame(16'h0050, 4'h0, 4'hF, "f0050");

    repeat (2) @(negedge clk);
    offer(16'h0007, 4'h0, 4'b0011);
    @(negedge clk);
    in_valid = 1'b0;
    check("ready7", {31'd0, in_ready}, 32'd0);
    wait_frame("load7", n);
    check_frame(16'h0007, 4'h0, 4'b0011, "f0007");

    // Async reset mid-slot with a frame pending.
    @(negedge clk);
    offer(16'h8888, 4'hF, 4'hF);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-rst digit", {28'd0, digit}, 32'd1);
    check("pre-rst ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst digit", {28'd0, digit}, 32'd0);
    check("arst seg", {24'd0, abcdefgh}, 32'd0);
    check("arst fd", {31'd0, frame_done}, 32'd0);
    check("arst ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_frame("post-rst", n);
    check("post-rst period", n, 32'd16);
    check_frame(16'h0000, 4'h0, 4'h0, "lost");
    check("post-rst ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
